// File: rtl/parity_pkg.sv
// Shared constants, types and the lane parity helper for the parity stream unit.
package parity_pkg;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  // Widest lane the helper supports; narrower lanes are zero-extended into it.
  localparam int MAX_LANE_W = 64;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_LANE_W = 8;
  localparam int DEF_LANES  = DEF_DATA_W / DEF_LANE_W;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_LANES-1:0]  par;
    logic [DEF_LANES-1:0]  err;
  } beat_rec_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  // Zero padding does not change the XOR, so one loop bound serves every lane width.
  function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] lane, input logic mode);
    logic p;
    p = (mode == MODE_ODD) ? 1'b1 : 1'b0;
    for (int i = 0; i < MAX_LANE_W; i++) begin
      p = p ^ lane[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/parity_stream_gen_check_if.sv
// Producer/consumer, control and status bundle for parity_stream_gen_check.
interface parity_stream_gen_check_if #(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16
);
  localparam int LANES = DATA_W / LANE_W;

  logic              mode_odd;
  logic              chk_en;
  logic              clr_err;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [LANES-1:0]  in_par;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LANES-1:0]  out_par;
  logic [LANES-1:0]  out_err;
  logic              err_sticky;
  logic [CNT_W-1:0]  err_count;

  modport master (
    output mode_odd, chk_en, clr_err, in_valid, in_data, in_par, out_ready,
    input  in_ready, out_valid, out_data, out_par, out_err, err_sticky, err_count
  );

  modport slave (
    input  mode_odd, chk_en, clr_err, in_valid, in_data, in_par, out_ready,
    output in_ready, out_valid, out_data, out_par, out_err, err_sticky, err_count
  );

endinterface

// File: rtl/parity_skid_buf.sv
// Generic 2-entry valid/ready buffer with a registered in_ready and no in->out combinational path.
module parity_skid_buf
  import parity_pkg::*;
#(
  parameter int PAYLOAD_W = 40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload
);

  buf_state_t           state_q;
  buf_state_t           state_d;
  logic                 in_ready_q;
  logic                 wr_ptr_q;
  logic                 rd_ptr_q;
  logic [PAYLOAD_W-1:0] slot_q [2];
  logic                 push;
  logic                 pop;

  assign push        = in_valid & in_ready_q;
  assign pop         = (state_q != BUF_EMPTY) & out_ready;
  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != BUF_EMPTY);
  assign out_payload = slot_q[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (push) state_d = BUF_ONE;
      BUF_ONE: begin
        if (push && !pop)      state_d = BUF_FULL;
        else if (!push && pop) state_d = BUF_EMPTY;
      end
      BUF_FULL:  if (pop) state_d = BUF_ONE;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  // in_ready is computed from the next occupancy so that a full buffer never accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BUF_EMPTY;
      in_ready_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      slot_q[0]  <= '0;
      slot_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != BUF_FULL);
      if (push) begin
        slot_q[wr_ptr_q] <= in_payload;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: rtl/parity_stream_gen_check.sv
// Multi-lane streaming parity generator/checker with a 2-entry skid buffer
// and saturating error accounting at the input side.
module parity_stream_gen_check
  import parity_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 8,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic reset,
  parity_stream_gen_check_if.slave bus
);

  localparam int LANES     = DATA_W / LANE_W;
  localparam int PAYLOAD_W = DATA_W + 2 * LANES;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [LANES-1:0]  par;
    logic [LANES-1:0]  err;
  } beat_t;

  logic [LANES-1:0] par_calc;
  logic [LANES-1:0] err_calc;
  beat_t            in_beat;
  beat_t            out_beat;
  logic             accept;
  logic             errored;
  logic [CNT_W-1:0] err_count_q;
  logic [CNT_W-1:0] err_count_d;
  logic             err_sticky_q;
  logic             err_sticky_d;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign par_calc[i] = lane_parity(MAX_LANE_W'(bus.in_data[i*LANE_W +: LANE_W]), bus.mode_odd);
    assign err_calc[i] = bus.chk_en & (par_calc[i] ^ bus.in_par[i]);
  end

  assign in_beat.data = bus.in_data;
  assign in_beat.par  = par_calc;
  assign in_beat.err  = err_calc;

  // Parity and compare results are captured with the beat, so later mode changes leave it untouched.
  parity_skid_buf #(
    .PAYLOAD_W(PAYLOAD_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (bus.in_valid),
    .in_ready   (bus.in_ready),
    .in_payload (in_beat),
    .out_valid  (bus.out_valid),
    .out_ready  (bus.out_ready),
    .out_payload(out_beat)
  );

  assign bus.out_data = out_beat.data;
  assign bus.out_par  = out_beat.par;
  assign bus.out_err  = out_beat.err;

  assign accept  = bus.in_valid & bus.in_ready;
  assign errored = accept & (|err_calc);

  // A clear is applied before the increment so a coincident errored beat still counts once.
  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    if (bus.clr_err) begin
      err_count_d  = '0;
      err_sticky_d = 1'b0;
    end
    if (errored) begin
      err_sticky_d = 1'b1;
      if (err_count_d != '1) begin
        err_count_d = err_count_d + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.err_count  = err_count_q;
  assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_parity_stream_gen_check.sv
// Randomised and directed bench for parity_stream_gen_check against a queue-based reference model.
module tb_parity_stream_gen_check;
  import parity_pkg::*;

  localparam int DATA_W  = 32;
  localparam int LANE_W  = 8;
  localparam int CNT_W   = 4;
  localparam int LANES   = DATA_W / LANE_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  parity_stream_gen_check_if #(.DATA_W(DATA_W), .LANE_W(LANE_W), .CNT_W(CNT_W)) bus ();

  parity_stream_gen_check #(.DATA_W(DATA_W), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  beat_rec_t   mq[$];
  logic        m_ready  = 1'b0;
  int unsigned m_cnt    = 0;
  logic        m_sticky = 1'b0;
  bit          m_live   = 1'b0;
  bit          last_accept = 1'b0;
  int          popped   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected beat from popcounts of each byte lane
  function automatic beat_rec_t refBeat(input logic [31:0] d, input logic odd,
                                        input logic chk, input logic [3:0] ip);
    beat_rec_t b;
    int ones;
    b.data = d;
    for (int i = 0; i < LANES; i++) begin
      ones = $countones((d >> (8 * i)) & 32'hFF);
      b.par[i] = ((ones % 2) == 1) ^ odd;
      b.err[i] = chk && (b.par[i] != ip[i]);
    end
    return b;
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic odd,
                               input logic chk, input logic [3:0] ip,
                               input logic ordy, input logic clr);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.mode_odd  = odd;
    bus.chk_en    = chk;
    bus.in_par    = ip;
    bus.out_ready = ordy;
    bus.clr_err   = clr;
  endtask

  task automatic tick();
    bit        acc;
    bit        con;
    bit        clr;
    bit        rst;
    beat_rec_t nb;
    if (m_live) begin
      checkOutput("in_ready", 64'(bus.in_ready), 64'(m_ready));
      checkOutput("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        checkOutput("out_data", 64'(bus.out_data), 64'(mq[0].data));
        checkOutput("out_par", 64'(bus.out_par), 64'(mq[0].par));
        checkOutput("out_err", 64'(bus.out_err), 64'(mq[0].err));
      end
      checkOutput("err_sticky", 64'(bus.err_sticky), 64'(m_sticky));
      checkOutput("err_count", 64'(bus.err_count), 64'(m_cnt));
    end
    acc = bus.in_valid && m_ready;
    con = bus.out_ready && (mq.size() > 0);
    clr = bus.clr_err;
    rst = reset;
    nb  = refBeat(bus.in_data, bus.mode_odd, bus.chk_en, bus.in_par);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_ready     = 1'b0;
      m_cnt       = 0;
      m_sticky    = 1'b0;
      m_live      = 1'b1;
      last_accept = 1'b0;
    end else begin
      if (con) begin
        void'(mq.pop_front());
        popped++;
      end
      if (acc) mq.push_back(nb);
      if (clr) begin
        m_cnt    = 0;
        m_sticky = 1'b0;
      end
      if (acc && nb.err != 0) begin
        m_sticky = 1'b1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
      m_ready     = (mq.size() < 2);
      last_accept = acc;
    end
    @(negedge clk);
  endtask

  initial begin
    int          sent;
    int          popped_start;
    logic [31:0] d;
    beat_rec_t   good;

    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, MODE_EVEN, 1'b0, 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    tick();
    tick();
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_data", 64'(bus.out_data), 64'd0);
    checkOutput("rst_out_par", 64'(bus.out_par), 64'd0);
    checkOutput("rst_out_err", 64'(bus.out_err), 64'd0);
    checkOutput("rst_err_count", 64'(bus.err_count), 64'd0);
    checkOutput("rst_err_sticky", 64'(bus.err_sticky), 64'd0);
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b0;
    tick();
    checkOutput("ready_after_reset", 64'(bus.in_ready), 64'd1);

    applyStimulus(1'b1, 32'h0000_00FF, MODE_EVEN, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, MODE_EVEN, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("ff_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("ff_par", 64'(bus.out_par), 64'b0000);
    checkOutput("ff_err", 64'(bus.out_err), 64'b0000);
    tick();

    applyStimulus(1'b1, 32'h0102_0307, MODE_ODD, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, MODE_EVEN, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("odd_par", 64'(bus.out_par), 64'b0010);
    checkOutput("odd_err_off", 64'(bus.out_err), 64'b0000);
    tick();

    applyStimulus(1'b1, 32'h0102_0307, MODE_ODD, 1'b1, 4'b0000, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, MODE_EVEN, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("chk_err", 64'(bus.out_err), 64'b0010);
    checkOutput("chk_sticky", 64'(bus.err_sticky), 64'd1);
    checkOutput("chk_count", 64'(bus.err_count), 64'd1);
    tick();

    applyStimulus(1'b1, 32'h0102_0407, MODE_ODD, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, MODE_EVEN, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();

    // Stall: consumer held off until cycle 7, producer always offering
    sent = 0;
    popped_start = popped;
    for (int c = 0; c < 60; c++) begin
      if (sent == 8 && mq.size() == 0) break;
      applyStimulus(sent < 8, 32'hA500_0000 | sent, 1'($urandom_range(0, 1)), 1'b0, 4'h0,
                    c >= 7, 1'b0);
      if (c == 4) checkOutput("stall_in_ready", 64'(bus.in_ready), 64'd0);
      tick();
      if (last_accept) sent++;
    end
    checkOutput("stream_count", 64'(popped - popped_start), 64'd8);

    // Saturation with deliberately wrong received parity
    for (int k = 0; k < 20; k++) begin
      d = $urandom;
      good = refBeat(d, MODE_EVEN, 1'b0, 4'h0);
      applyStimulus(1'b1, d, MODE_EVEN, 1'b1, ~good.par, 1'b1, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, MODE_EVEN, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("sat_count", 64'(bus.err_count), 64'hF);
    d = $urandom;
    good = refBeat(d, MODE_ODD, 1'b0, 4'h0);
    applyStimulus(1'b1, d, MODE_ODD, 1'b1, ~good.par, 1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, MODE_EVEN, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("clr_with_err_count", 64'(bus.err_count), 64'd1);
    checkOutput("clr_with_err_sticky", 64'(bus.err_sticky), 64'd1);
    tick();

    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom % 4) != 0, $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    ($urandom % 3) != 0, ($urandom % 40) == 0);
      tick();
    end

    // Reset with both entries occupied
    applyStimulus(1'b0, 32'h0, MODE_EVEN, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    tick();
    tick();
    applyStimulus(1'b1, 32'h1234_5678, MODE_EVEN, 1'b1, 4'hF, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 32'h9ABC_DEF0, MODE_ODD, 1'b1, 4'h0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, MODE_EVEN, 1'b0, 4'h0, 1'b0, 1'b0);
    checkOutput("full_before_reset", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;
    tick();
    checkOutput("mid_reset_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mid_reset_count", 64'(bus.err_count), 64'd0);
    reset = 1'b0;
    tick();
    applyStimulus(1'b1, 32'hDEAD_BEEF, MODE_EVEN, 1'b0, 4'h0, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, MODE_EVEN, 1'b0, 4'h0, 1'b1, 1'b0);
    checkOutput("post_reset_latency", 64'(bus.out_valid), 64'd1);
    checkOutput("post_reset_data", 64'(bus.out_data), 64'hDEAD_BEEF);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
